pc_flow_controller: RTL and testbench
=====================================

Name: pc_flow_controller

Overview:
Sequencing controller for the fetch-stage PC generator and the IF/ID and ID/EX pipeline registers. Arbitrates redirect sources (trap, EX branch, ID jump) against stall sources (instruction-memory wait, load-use hazard). Drives the PC generator's stall/flush/new_pc inputs and the pipeline-register stall/flush controls. Holds redirects that arrive during a fetch wait, and drains the pipeline before trap entry.

Parameters:
XLEN, 32, data/address width
RESET_VECTOR, 32'h00000000, value driven on pc_new while reset is asserted
DRAIN_CYCLES, 2, cycles of pipeline drain before trap redirect (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_ready  input  1  instruction memory returned the current fetch
load_use_hazard  input  1  ID instruction depends on a load in EX
id_jump_valid  input  1  JAL decoded in ID
id_jump_target  input  XLEN  JAL target
ex_branch_taken  input  1  branch/JALR resolved taken in EX
ex_branch_target  input  XLEN  resolved target
trap_req  input  1  exception/interrupt request
trap_vector  input  XLEN  trap handler address
trap_ack  output  1  one-cycle pulse when trap_req is accepted
pc_stall  output  1  to pc_generator stall
pc_flush  output  1  to pc_generator flush
pc_new  output  XLEN  to pc_generator new_pc
ifid_stall  output  1  hold IF/ID register
ifid_flush  output  1  bubble IF/ID register
idex_flush  output  1  bubble ID/EX register

Behaviour:
- The FSM has 4 states: RUN, PEND, DRAIN, TRAP_JUMP. Registered state: fsm, pend_target, trap_target_q, drain_cnt (4 bit).
- All outputs are combinational from state and inputs, so they take effect at the next clock edge (zero-cycle decision latency).
- While reset=1: fsm=RUN. All 1-bit outputs are 0. pc_new=RESET_VECTOR. Registers are cleared.
- Reset asserted mid-operation aborts PEND/DRAIN immediately. A pending target is discarded.
- pc_flush and pc_stall are never both 1.
- pc_new=0 whenever pc_flush=0 (outside reset).
- RUN state, fixed priority from highest to lowest:
  1. trap_req: trap_ack=1, pc_stall=1, ifid_flush=1, idex_flush=1. Latch trap_vector. drain_cnt=DRAIN_CYCLES-1. Next state DRAIN.
  2. ex_branch_taken with imem_ready=1: pc_flush=1, pc_new=ex_branch_target, ifid_flush=1, idex_flush=1. Stay in RUN.
  3. ex_branch_taken with imem_ready=0: pc_stall=1, ifid_flush=1, idex_flush=1. Latch pend_target. Next state PEND.
  4. id_jump_valid with imem_ready=1: pc_flush=1, pc_new=id_jump_target, ifid_flush=1. idex_flush=0.
  5. id_jump_valid with imem_ready=0: same as case 3 but latch id_jump_target; idex_flush=0. Next state PEND.
  6. imem_ready=0: pc_stall=1, ifid_flush=1.
  7. load_use_hazard: pc_stall=1, ifid_stall=1, idex_flush=1.
  8. Otherwise all outputs are 0.
- An ex_branch_taken that coincides with load_use_hazard wins. The hazard is dropped because the instruction is flushed.
- PEND state:
  - pc_stall=1, ifid_flush=1, idex_flush=1.
  - id_jump_valid, ex_branch_taken and load_use_hazard are ignored.
  - trap_req behaves as in RUN case 1 and discards pend_target.
  - When imem_ready=1: pc_flush=1 (pc_stall=0), pc_new=pend_target. Next state RUN.
- DRAIN state:
  - pc_stall=1, ifid_flush=1, idex_flush=1. All request inputs are ignored.
  - drain_cnt decrements each cycle.
  - When drain_cnt==0, next state is TRAP_JUMP.
  - DRAIN lasts exactly DRAIN_CYCLES cycles.
- TRAP_JUMP state:
  - If imem_ready=1: pc_flush=1, pc_new=trap_target_q, ifid_flush=1, idex_flush=1. Next state RUN.
  - If imem_ready=0: pc_stall=1, both flushes asserted. Stay in TRAP_JUMP.
  - trap_req is not acknowledged again until the FSM is back in RUN.
- Unreachable state encodings recover to RUN.

Optional Feature:
Macro PC_FLOW_PERF_EN.
- When defined, two extra outputs exist:
  - stall_cycles [31:0]: counts cycles with pc_stall=1.
  - redirect_count [31:0]: counts cycles with pc_flush=1.
  - Both reset to 0 and wrap modulo 2^32.
- When not defined, these ports and counters are absent. Core behaviour is identical.

Test Plan:
1. Reset held with all inputs at 0 -> pc_new=0x00000000, all flags 0. After release with imem_ready=1, outputs stay 0.
2. RUN, ex_branch_taken=1, target 0x00000100, imem_ready=1 -> same cycle pc_flush=1, pc_new=0x100, ifid_flush=idex_flush=1. Next cycle all outputs 0.
3. ex_branch_taken with target 0x200 while imem_ready=0, then imem_ready held 0 for 3 cycles -> pc_stall=1 for 4 cycles. The cycle imem_ready=1 gives pc_flush=1, pc_new=0x200.
4. load_use_hazard=1 for 1 cycle -> pc_stall=1, ifid_stall=1, idex_flush=1 for that cycle only. With id_jump_valid (0x40) simultaneous -> jump wins: pc_flush=1, pc_new=0x40, idex_flush=0.
5. trap_req=1 with vector 0x80000000 plus ex_branch_taken in the same cycle, DRAIN_CYCLES=2 -> trap_ack pulse. pc_stall=1 for 3 cycles (accept + 2 drain). Then pc_flush=1, pc_new=0x80000000, and the branch is discarded.
6. Reset asserted during DRAIN and again during PEND -> outputs return to reset values immediately. After release, no stale redirect is issued.

Source files
------------

// File: rtl/pc_flow_controller.sv
// pc_flow_controller: fetch/decode sequencing controller.
// Arbitrates trap, EX-branch and ID-jump redirects against imem-wait and
// load-use stalls, driving the PC generator and IF/ID, ID/EX controls.
// Optional build macro PC_FLOW_PERF_EN adds stall/redirect cycle counters.
module pc_flow_controller #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_ready,
  input  logic            load_use_hazard,
  input  logic            id_jump_valid,
  input  logic [XLEN-1:0] id_jump_target,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  output logic            trap_ack,
  output logic            pc_stall,
  output logic            pc_flush,
  output logic [XLEN-1:0] pc_new,
  output logic            ifid_stall,
  output logic            ifid_flush,
  output logic            idex_flush
`ifdef PC_FLOW_PERF_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     redirect_count
`endif
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] PEND      = 2'd1;
  localparam logic [1:0] DRAIN     = 2'd2;
  localparam logic [1:0] TRAP_JUMP = 2'd3;

  logic [1:0]      fsm, fsm_next;
  logic [XLEN-1:0] pend_target, pend_next;
  logic [XLEN-1:0] trap_target_q, trap_next;
  logic [3:0]      drain_cnt, cnt_next;
  logic            accept_trap;

  // Traps are only taken from RUN or PEND; PEND's held target is dropped.
  assign accept_trap = trap_req && ((fsm == RUN) || (fsm == PEND));

  // Output decode and next-state selection, purely from state and inputs.
  always_comb begin
    trap_ack   = 1'b0;
    pc_stall   = 1'b0;
    pc_flush   = 1'b0;
    pc_new     = '0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    fsm_next   = fsm;
    pend_next  = pend_target;
    trap_next  = trap_target_q;
    cnt_next   = drain_cnt;
    if (reset) begin
      pc_new   = RESET_VECTOR;
      fsm_next = RUN;
    end else if (accept_trap) begin
      trap_ack   = 1'b1;
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      trap_next  = trap_vector;
      pend_next  = '0;
      cnt_next   = 4'(DRAIN_CYCLES - 1);
      fsm_next   = DRAIN;
    end else begin
      case (fsm)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (imem_ready) begin
              pc_flush = 1'b1;
              pc_new   = ex_branch_target;
            end else begin
              pc_stall  = 1'b1;
              pend_next = ex_branch_target;
              fsm_next  = PEND;
            end
          end else if (id_jump_valid) begin
            ifid_flush = 1'b1;
            if (imem_ready) begin
              pc_flush = 1'b1;
              pc_new   = id_jump_target;
            end else begin
              pc_stall  = 1'b1;
              pend_next = id_jump_target;
              fsm_next  = PEND;
            end
          end else if (!imem_ready) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
          end else if (load_use_hazard) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        PEND: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (imem_ready) begin
            pc_flush = 1'b1;
            pc_new   = pend_target;
            fsm_next = RUN;
          end else begin
            pc_stall = 1'b1;
          end
        end
        DRAIN: begin
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (drain_cnt == 4'd0) begin
            cnt_next = '0;
            fsm_next = TRAP_JUMP;
          end else begin
            cnt_next = drain_cnt - 4'd1;
          end
        end
        TRAP_JUMP: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (imem_ready) begin
            pc_flush = 1'b1;
            pc_new   = trap_target_q;
            fsm_next = RUN;
          end else begin
            pc_stall = 1'b1;
          end
        end
        default: fsm_next = RUN;
      endcase
    end
  end

  // State and held-target registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm           <= RUN;
      pend_target   <= '0;
      trap_target_q <= '0;
      drain_cnt     <= '0;
    end else begin
      fsm           <= fsm_next;
      pend_target   <= pend_next;
      trap_target_q <= trap_next;
      drain_cnt     <= cnt_next;
    end
  end

`ifdef PC_FLOW_PERF_EN
  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (pc_stall) stall_cycles   <= stall_cycles + 32'd1;
      if (pc_flush) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_flow_controller.sv
// Testbench for pc_flow_controller: directed scenarios plus randomized
// traffic checked against a behavioural model of the sequencing rules.
module tb_pc_flow_controller;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready, load_use_hazard, id_jump_valid, ex_branch_taken, trap_req;
  logic [31:0] id_jump_target, ex_branch_target, trap_vector;
  logic        trap_ack, pc_stall, pc_flush, ifid_stall, ifid_flush, idex_flush;
  logic [31:0] pc_new;
  logic [5:0]  flags;

  int n_pass  = 0;
  int n_total = 0;

  // flags = {trap_ack, pc_stall, pc_flush, ifid_stall, ifid_flush, idex_flush}
  assign flags = {trap_ack, pc_stall, pc_flush, ifid_stall, ifid_flush, idex_flush};

  pc_flow_controller #(.XLEN(32), .RESET_VECTOR(32'h00000000), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .load_use_hazard(load_use_hazard),
    .id_jump_valid(id_jump_valid), .id_jump_target(id_jump_target),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .trap_req(trap_req), .trap_vector(trap_vector), .trap_ack(trap_ack),
    .pc_stall(pc_stall), .pc_flush(pc_flush), .pc_new(pc_new),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic apply(input logic r, input logic rdy, input logic hz,
                       input logic jv, input logic [31:0] jt,
                       input logic bt, input logic [31:0] btg,
                       input logic tr, input logic [31:0] tv);
    @(negedge clk);
    reset = r; imem_ready = rdy; load_use_hazard = hz;
    id_jump_valid = jv; id_jump_target = jt;
    ex_branch_taken = bt; ex_branch_target = btg;
    trap_req = tr; trap_vector = tv;
    #1;
  endtask

  task automatic test_reset;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b000000 || pc_new !== 32'h0)
      $display("FAIL reset_hold: flags=%b pc_new=%h want 000000 00000000", flags, pc_new);
    else n_pass++;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
      n_total++;
      if (flags !== 6'b000000 || pc_new !== 32'h0)
        $display("FAIL reset_release[%0d]: flags=%b pc_new=%h want 000000 00000000", i, flags, pc_new);
      else n_pass++;
    end
  endtask

  task automatic test_branch;
    apply(0, 1, 0, 0, 0, 1, 32'h100, 0, 0);
    n_total++;
    if (flags !== 6'b001011 || pc_new !== 32'h100)
      $display("FAIL branch_ready: flags=%b pc_new=%h want 001011 00000100", flags, pc_new);
    else n_pass++;
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b000000 || pc_new !== 32'h0)
      $display("FAIL branch_after: flags=%b pc_new=%h want 000000 00000000", flags, pc_new);
    else n_pass++;
  endtask

  task automatic test_pend;
    apply(0, 0, 0, 0, 0, 1, 32'h200, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) apply(0, 0, 1, 1, 32'h44, 1, 32'h999, 0, 0);
      n_total++;
      if (flags !== 6'b010011 || pc_new !== 32'h0)
        $display("FAIL pend_wait[%0d]: flags=%b pc_new=%h want 010011 00000000", i, flags, pc_new);
      else n_pass++;
    end
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b001011 || pc_new !== 32'h200)
      $display("FAIL pend_release: flags=%b pc_new=%h want 001011 00000200", flags, pc_new);
    else n_pass++;
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b000000)
      $display("FAIL pend_after: flags=%b want 000000", flags);
    else n_pass++;
  endtask

  task automatic test_hazard_jump;
    apply(0, 1, 1, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b010101 || pc_new !== 32'h0)
      $display("FAIL load_use: flags=%b pc_new=%h want 010101 00000000", flags, pc_new);
    else n_pass++;
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b000000)
      $display("FAIL load_use_after: flags=%b want 000000", flags);
    else n_pass++;
    apply(0, 1, 1, 1, 32'h40, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b001010 || pc_new !== 32'h40)
      $display("FAIL jump_over_hazard: flags=%b pc_new=%h want 001010 00000040", flags, pc_new);
    else n_pass++;
    apply(0, 1, 1, 0, 0, 1, 32'h500, 0, 0);
    n_total++;
    if (flags !== 6'b001011 || pc_new !== 32'h500)
      $display("FAIL branch_over_hazard: flags=%b pc_new=%h want 001011 00000500", flags, pc_new);
    else n_pass++;
  endtask

  task automatic test_trap;
    apply(0, 1, 0, 0, 0, 1, 32'h300, 1, 32'h80000000);
    n_total++;
    if (flags !== 6'b110011 || pc_new !== 32'h0)
      $display("FAIL trap_accept: flags=%b pc_new=%h want 110011 00000000", flags, pc_new);
    else n_pass++;
    for (int i = 0; i < DRAIN; i++) begin
      apply(0, 1, 1, 1, 32'h60, 1, 32'h300, 1, 32'h12345678);
      n_total++;
      if (flags !== 6'b010011 || pc_new !== 32'h0)
        $display("FAIL trap_drain[%0d]: flags=%b pc_new=%h want 010011 00000000", i, flags, pc_new);
      else n_pass++;
    end
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b001011 || pc_new !== 32'h80000000)
      $display("FAIL trap_jump: flags=%b pc_new=%h want 001011 80000000", flags, pc_new);
    else n_pass++;
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b000000)
      $display("FAIL trap_after: flags=%b want 000000", flags);
    else n_pass++;
  endtask

  task automatic test_reset_midop;
    apply(0, 1, 0, 0, 0, 0, 0, 1, 32'hC0000000);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b000000 || pc_new !== 32'h0)
      $display("FAIL reset_in_drain: flags=%b pc_new=%h want 000000 00000000", flags, pc_new);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
      n_total++;
      if (flags !== 6'b000000 || pc_new !== 32'h0)
        $display("FAIL after_drain_reset[%0d]: flags=%b pc_new=%h want 000000 00000000", i, flags, pc_new);
      else n_pass++;
    end
    apply(0, 0, 0, 1, 32'h700, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (flags !== 6'b000000 || pc_new !== 32'h0)
      $display("FAIL reset_in_pend: flags=%b pc_new=%h want 000000 00000000", flags, pc_new);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
      n_total++;
      if (flags !== 6'b000000 || pc_new !== 32'h0)
        $display("FAIL after_pend_reset[%0d]: flags=%b pc_new=%h want 000000 00000000", i, flags, pc_new);
      else n_pass++;
    end
  endtask

  // Model: a pending redirect flag, a count of drain cycles still owed,
  // and a flag for a trap jump waiting on the fetch port.
  task automatic test_random;
    bit          m_pend = 0, m_tj = 0;
    int          m_drain = 0;
    logic [31:0] m_ptgt = 0, m_trap = 0;
    logic [5:0]  exp_f;
    logic [31:0] exp_pc;
    logic        r, rdy, hz, jv, bt, tr;
    logic [31:0] jt, btg, tv;
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(99) < 3);
      rdy = ($urandom_range(99) < 70);
      hz  = ($urandom_range(99) < 25);
      jv  = ($urandom_range(99) < 20);
      bt  = ($urandom_range(99) < 20);
      tr  = ($urandom_range(99) < 8);
      jt = $urandom; btg = $urandom; tv = $urandom;
      apply(r, rdy, hz, jv, jt, bt, btg, tr, tv);
      exp_f = 6'b000000; exp_pc = 32'h0;
      if (r) begin
        m_pend = 0; m_tj = 0; m_drain = 0;
      end else if (m_drain > 0) begin
        exp_f = 6'b010011;
        m_drain--;
        if (m_drain == 0) m_tj = 1;
      end else if (m_tj) begin
        if (rdy) begin exp_f = 6'b001011; exp_pc = m_trap; m_tj = 0; end
        else exp_f = 6'b010011;
      end else if (tr) begin
        exp_f = 6'b110011; m_trap = tv; m_drain = DRAIN; m_pend = 0;
      end else if (m_pend) begin
        if (rdy) begin exp_f = 6'b001011; exp_pc = m_ptgt; m_pend = 0; end
        else exp_f = 6'b010011;
      end else if (bt) begin
        if (rdy) begin exp_f = 6'b001011; exp_pc = btg; end
        else begin exp_f = 6'b010011; m_pend = 1; m_ptgt = btg; end
      end else if (jv) begin
        if (rdy) begin exp_f = 6'b001010; exp_pc = jt; end
        else begin exp_f = 6'b010010; m_pend = 1; m_ptgt = jt; end
      end else if (!rdy) begin
        exp_f = 6'b010010;
      end else if (hz) begin
        exp_f = 6'b010101;
      end
      n_total++;
      if (flags !== exp_f || pc_new !== exp_pc)
        $display("FAIL random[%0d]: flags=%b pc_new=%h want %b %h", c, flags, pc_new, exp_f, exp_pc);
      else n_pass++;
      n_total++;
      if ((pc_stall && pc_flush) || (!pc_flush && pc_new !== 32'h0))
        $display("FAIL random_invariant[%0d]: stall=%b flush=%b pc_new=%h", c, pc_stall, pc_flush, pc_new);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; load_use_hazard = 1'b0; id_jump_valid = 1'b0;
    ex_branch_taken = 1'b0; trap_req = 1'b0;
    id_jump_target = '0; ex_branch_target = '0; trap_vector = '0;
    test_reset;
    test_branch;
    test_pend;
    test_hazard_jump;
    test_trap;
    test_reset_midop;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
